// File: rtl/front_panel_loader.sv
// Front-panel loader: deposits an image into the CPU through the switch/button panel,
// then loads the start PC, runs the program and waits for it to halt.
module front_panel_loader #(
    parameter int unsigned HOLD_CYCLES   = 10,
    parameter int unsigned SETTLE_CYCLES = 30
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        req_valid,
    input  logic [11:0] req_addr,
    input  logic [11:0] req_data,
    input  logic        req_last,
    output logic        req_ready,
    input  logic [11:0] start_pc,
    output logic [12:0] sw,
    output logic        load_pc_btn,
    output logic        deposit_btn,
    input  logic        run_led,
    output logic        busy,
    output logic        done,
    output logic [12:0] words_loaded
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned WL_W    = 13;
    localparam int unsigned WL_MAX  = 4096;
    localparam logic [CNT_W-1:0] HOLD_RELOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, SET_ADDR, PRESS_LP, RELEASE_LP, SET_DATA, PRESS_DEP, RELEASE_DEP,
        SET_START, PRESS_START, RELEASE_START, RUN, FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       addr_q, addr_d, data_q, data_d, pc_q, pc_d, next_addr_q, next_addr_d;
    logic              last_q, last_d, seq_valid_q, seq_valid_d;
    logic              clr_pend_q, clr_pend_d, seen_q, seen_d;
    logic [WL_W-1:0]   words_q, words_d;
    logic [12:0]       sw_q, sw_d;
    logic              lp_q, lp_d, dep_q, dep_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic              expired;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            pc_q        <= '0;
            next_addr_q <= '0;
            last_q      <= 1'b0;
            seq_valid_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            seen_q      <= 1'b0;
            words_q     <= '0;
            sw_q        <= '0;
            lp_q        <= 1'b0;
            dep_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pc_q        <= pc_d;
            next_addr_q <= next_addr_d;
            last_q      <= last_d;
            seq_valid_q <= seq_valid_d;
            clr_pend_q  <= clr_pend_d;
            seen_q      <= seen_d;
            words_q     <= words_d;
            sw_q        <= sw_d;
            lp_q        <= lp_d;
            dep_q       <= dep_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pc_d        = pc_q;
        next_addr_d = next_addr_q;
        last_d      = last_q;
        seq_valid_d = seq_valid_q;
        clr_pend_d  = clr_pend_q;
        seen_d      = seen_q;
        words_d     = words_q;
        expired     = (cnt_q == '0);

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    last_d = req_last;
                    if (clr_pend_q) begin
                        words_d    = '0;
                        clr_pend_d = 1'b0;
                    end
                    // Consecutive addresses skip the load-PC step: the CPU auto-increments.
                    state_d = (seq_valid_q && (req_addr == next_addr_q)) ? SET_DATA : SET_ADDR;
                end
            end
            SET_ADDR:    if (expired) state_d = PRESS_LP;
            PRESS_LP:    if (expired) state_d = RELEASE_LP;
            RELEASE_LP:  if (expired) state_d = SET_DATA;
            SET_DATA:    if (expired) state_d = PRESS_DEP;
            PRESS_DEP:   if (expired) state_d = RELEASE_DEP;
            RELEASE_DEP: begin
                if (expired) begin
                    next_addr_d = addr_q + 12'd1;
                    seq_valid_d = 1'b1;
                    if (words_q != WL_W'(WL_MAX)) words_d = words_q + 13'd1;
                    if (last_q) begin
                        state_d = SET_START;
                        pc_d    = start_pc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SET_START:   if (expired) state_d = PRESS_START;
            PRESS_START: if (expired) state_d = RELEASE_START;
            RELEASE_START: begin
                if (expired) begin
                    seq_valid_d = 1'b0;
                    seen_d      = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                // Halt is the falling edge of run_led, so a low level before it rises is ignored.
                if (run_led)     seen_d  = 1'b1;
                else if (seen_q) state_d = FINISH;
            end
            FINISH: begin
                clr_pend_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = (state_d == RELEASE_LP) ? SETTLE_RELOAD : HOLD_RELOAD;
        else if (!expired)      cnt_d = cnt_q - CNT_W'(1);

        // Outputs are registered from the next state so they align with state_q.
        unique case (state_d)
            SET_ADDR, PRESS_LP, RELEASE_LP:         sw_d = {1'b0, addr_d};
            SET_DATA, PRESS_DEP, RELEASE_DEP:       sw_d = {1'b0, data_d};
            SET_START, PRESS_START, RELEASE_START:  sw_d = {1'b0, pc_d};
            RUN:                                    sw_d = 13'h1000;
            default:                                sw_d = '0;
        endcase
        lp_d    = (state_d == PRESS_LP) || (state_d == PRESS_START);
        dep_d   = (state_d == PRESS_DEP);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
        ready_d = (state_d == IDLE);
    end

    assign req_ready    = ready_q;
    assign sw           = sw_q;
    assign load_pc_btn  = lp_q;
    assign deposit_btn  = dep_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_front_panel_loader.sv
// Bench for front_panel_loader: directed and random image loads checked against
// an address/sequence model and the panel timing rules.
module tb_front_panel_loader;

    localparam int H = 10;
    localparam int S = 30;

    logic        clock = 1'b0;
    logic        resetN;
    logic        req_valid, req_last, req_ready, run_led;
    logic [11:0] req_addr, req_data, start_pc;
    logic [12:0] sw, words_loaded;
    logic        load_pc_btn, deposit_btn, busy, done;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    logic [11:0] m_next  = '0;
    bit          m_seq   = 1'b0;
    int          m_words = 0;
    bit          m_clr   = 1'b0;

    front_panel_loader #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S)) dut (
        .clock(clock), .resetN(resetN),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .start_pc(start_pc), .sw(sw),
        .load_pc_btn(load_pc_btn), .deposit_btn(deposit_btn), .run_led(run_led),
        .busy(busy), .done(done), .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic [11:0] a, input bit last);
        m_next = a + 12'd1;
        m_seq  = 1'b1;
        if (m_words < 4096) m_words++;
        chk("words_loaded", 32'(words_loaded), 32'(m_words));
        if (last) m_seq = 1'b0;
    endtask

    // Observe one word from the cycle after accept until ready returns (or RUN starts).
    task automatic track(input logic [11:0] a, input logic [11:0] d, input bit last,
                         input logic [11:0] spc, input bit nonseq);
        int cyc = 1; int lp_n = 0; int dep_n = 0; int bad = 0; int ovl = 0;
        int nb = 0; int dn = 0; bit to = 1'b0; int exp_lat;
        forever begin
            if (req_ready || sw[12]) break;
            if (load_pc_btn && deposit_btn) ovl++;
            if (load_pc_btn) begin
                lp_n++;
                if (sw[11:0] !== ((dep_n > 0) ? spc : a)) bad++;
            end
            if (deposit_btn) begin
                dep_n++;
                if (sw[11:0] !== d) bad++;
            end
            if (busy !== 1'b1) nb++;
            if (done !== 1'b0) dn++;
            if (cyc >= 400) begin to = 1'b1; break; end
            @(negedge clock);
            cyc++;
        end
        exp_lat = (nonseq ? 5*H + S : 3*H) + 1 + (last ? 3*H : 0);
        chk("timeout", 32'(to), 0);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("load_pc_cycles", 32'(lp_n), 32'((nonseq ? H : 0) + (last ? H : 0)));
        chk("deposit_cycles", 32'(dep_n), 32'(H));
        chk("sw_during_press", 32'(bad), 0);
        chk("one_button", 32'(ovl), 0);
        chk("busy_while_loading", 32'(nb), 0);
        chk("no_done_while_loading", 32'(dn), 0);
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] d, input bit last,
                        input logic [11:0] spc);
        bit nonseq; int w = 0;
        while (req_ready !== 1'b1 && w < 1000) begin @(negedge clock); w++; end
        chk("ready_before_send", 32'(req_ready), 1);
        if (m_clr) begin m_words = 0; m_clr = 1'b0; end
        nonseq    = !(m_seq && (a == m_next));
        req_valid = 1'b1; req_addr = a; req_data = d; req_last = last; start_pc = spc;
        @(negedge clock);
        req_valid = 1'b0;
        track(a, d, last, spc, nonseq);
        commit(a, last);
    endtask

    task automatic run_program(input int pre_low, input int high_len, input bit poke);
        int bad = 0; int rdy = 0;
        chk("run_sw12", 32'(sw[12]), 1);
        run_led = 1'b0;
        repeat (pre_low) begin
            if (poke) begin req_valid = 1'b1; req_addr = 12'($urandom_range(0, 4095)); end
            @(negedge clock);
            if (done !== 1'b0 || sw[12] !== 1'b1) bad++;
            if (req_ready !== 1'b0) rdy++;
        end
        req_valid = 1'b0;
        run_led   = 1'b1;
        repeat (high_len) begin
            @(negedge clock);
            if (done !== 1'b0 || sw[12] !== 1'b1) bad++;
        end
        run_led = 1'b0;
        @(negedge clock);
        chk("run_hold", 32'(bad), 0);
        if (poke) chk("no_accept_while_busy", 32'(rdy), 0);
        chk("done_pulse", 32'(done), 1);
        @(negedge clock);
        chk("done_one_cycle", 32'(done), 0);
        chk("sw12_after_run", 32'(sw[12]), 0);
        chk("ready_after_run", 32'(req_ready), 1);
        m_clr = 1'b1;
        m_seq = 1'b0;
    endtask

    initial begin
        logic [11:0] a, d;
        bit last;
        int w;
        resetN = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_last = 1'b0;
        start_pc = '0; run_led = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_sw", 32'(sw), 0);
        chk("reset_buttons", 32'({load_pc_btn, deposit_btn}), 0);
        chk("reset_busy_done", 32'({busy, done}), 0);
        chk("reset_words", 32'(words_loaded), 0);
        resetN = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 32'(req_ready), 1);

        send(12'o0200, 12'o7402, 1'b0, 12'o0000);
        send(12'o0200, 12'o1234, 1'b0, 12'o0000);
        send(12'o0201, 12'o4321, 1'b0, 12'o0000);
        send(12'o0300, 12'o1111, 1'b0, 12'o0000);
        send(12'o7777, 12'o2222, 1'b0, 12'o0000);
        send(12'o0000, 12'o3333, 1'b0, 12'o0000);
        send(12'o0001, 12'o7402, 1'b1, 12'o0200);
        run_program(3, 50, 1'b0);

        for (int i = 0; i < 16; i++) begin
            a    = ($urandom_range(0, 1) == 1) ? m_next : 12'($urandom_range(0, 4095));
            d    = 12'($urandom_range(0, 4095));
            last = ($urandom_range(0, 4) == 0);
            send(a, d, last, 12'($urandom_range(0, 4095)));
            if (last) run_program($urandom_range(0, 5), $urandom_range(1, 20), 1'b0);
        end

        send(12'($urandom_range(0, 4095)), 12'o5555, 1'b1, 12'($urandom_range(0, 4095)));
        run_program(100, 5, 1'b1);

        // Reset in the middle of a deposit press, with a word already waiting.
        if (m_clr) begin m_words = 0; m_clr = 1'b0; end
        req_valid = 1'b1; req_addr = m_next + 12'd7; req_data = 12'o6060; req_last = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        w = 0;
        while (deposit_btn !== 1'b1 && w < 200) begin @(negedge clock); w++; end
        chk("reached_press_dep", 32'(deposit_btn), 1);
        resetN = 1'b0;
        #1;
        chk("reset_drops_deposit", 32'(deposit_btn), 0);
        chk("reset_clears_words", 32'(words_loaded), 0);
        chk("reset_clears_busy", 32'(busy), 0);
        chk("reset_clears_sw", 32'(sw), 0);
        a = 12'o2000; d = 12'o0707;
        req_valid = 1'b1; req_addr = a; req_data = d; req_last = 1'b0;
        @(negedge clock);
        resetN  = 1'b1;
        m_seq   = 1'b0;
        m_words = 0;
        m_clr   = 1'b0;
        #1;
        chk("ready_after_release", 32'(req_ready), 1);
        @(negedge clock);
        req_valid = 1'b0;
        track(a, d, 1'b0, 12'o0000, 1'b1);
        commit(a, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
